// File: rtl/booth_multiplier.sv
// ============================================================================
// Module      : booth_multiplier
// Description : Sequential radix-2 Booth multiplier, signed WIDTH x WIDTH
//               operands producing a 2*WIDTH-bit signed product.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam int c_cnt_w = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH:0]       r_m;
    logic [WIDTH:0]       r_acc;
    logic [WIDTH-1:0]     r_q;
    logic                 r_q_1;
    logic [c_cnt_w-1:0]   r_count;
    logic [2*WIDTH-1:0]   r_product;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_acc_nxt;
    logic [WIDTH-1:0]     w_q_nxt;
    logic                 w_last;

    assign w_last = (r_count == c_cnt_w'(1));

    // The extra accumulator bit keeps acc - M exact when A is the most negative value.
    always_comb begin
        w_sum = r_acc;
        case ({r_q[0], r_q_1})
            2'b01:   w_sum = r_acc + r_m;
            2'b10:   w_sum = r_acc - r_m;
            default: w_sum = r_acc;
        endcase
        w_acc_nxt = {w_sum[WIDTH], w_sum[WIDTH:1]};
        w_q_nxt   = {w_sum[0], r_q[WIDTH-1:1]};
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_CALC;
            S_CALC:  if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m       <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_q_1     <= 1'b0;
            r_count   <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_m     <= {A[WIDTH-1], A};
                        r_q     <= B;
                        r_acc   <= '0;
                        r_q_1   <= 1'b0;
                        r_count <= c_cnt_w'(WIDTH);
                    end
                end
                S_CALC: begin
                    r_acc   <= w_acc_nxt;
                    r_q     <= w_q_nxt;
                    r_q_1   <= r_q[0];
                    r_count <= r_count - c_cnt_w'(1);
                    // Product is loaded on entry to DONE so it is valid alongside the done pulse.
                    if (w_last) begin
                        r_product <= {w_acc_nxt[WIDTH-1:0], w_q_nxt};
                    end
                end
                default: ;
            endcase
        end
    end

    assign product = r_product;
    assign busy    = (r_state == S_CALC);
    assign done    = (r_state == S_DONE);

endmodule

`default_nettype wire
